// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer.
// Holds command codes, FSM states and flag bit positions.
package alu_sequencer_pkg;

  localparam int CMD_W  = 4;
  localparam int FLAG_W = 4;

  localparam logic [CMD_W-1:0] CMD_ADD       = 4'd0;
  localparam logic [CMD_W-1:0] CMD_SUB       = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SHL       = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL_ALT   = 4'd3;
  localparam logic [CMD_W-1:0] CMD_EQ        = 4'd4;
  localparam logic [CMD_W-1:0] CMD_GT        = 4'd5;
  localparam logic [CMD_W-1:0] CMD_LT        = 4'd6;
  localparam logic [CMD_W-1:0] CMD_MAX_LEGAL = 4'd6;

  localparam int FLAG_OVER  = 0;
  localparam int FLAG_UNDER = 1;
  localparam int FLAG_LOG   = 2;
  localparam int FLAG_ERR   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_cmp(input logic [CMD_W-1:0] cmd);
    return (cmd >= CMD_EQ) && (cmd <= CMD_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/alu_sequencer_flag_mask.sv
// Per-command masking of raw ALU result and flags.
// Flags not produced by the current command are forced low.
module alu_flag_mask
  import alu_sequencer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [N-1:0]      out_i,
  input  logic              over_i,
  input  logic              under_i,
  input  logic              log_i,
  output logic [N-1:0]      data_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              acc_we_o
);

  always_comb begin
    data_o   = '0;
    flags_o  = '0;
    acc_we_o = 1'b0;
    unique case (1'b1)
      (cmd_i == CMD_ADD): begin
        data_o             = out_i;
        flags_o[FLAG_OVER] = over_i;
        acc_we_o           = 1'b1;
      end
      (cmd_i == CMD_SUB): begin
        data_o              = out_i;
        flags_o[FLAG_UNDER] = under_i;
        acc_we_o            = 1'b1;
      end
      (cmd_i == CMD_SHL),
      (cmd_i == CMD_SHL_ALT): begin
        data_o   = out_i;
        acc_we_o = 1'b1;
      end
      is_cmp(cmd_i): begin
        flags_o[FLAG_LOG] = log_i;
      end
      default: begin
        flags_o[FLAG_ERR] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Registered front-end for the combinational ALU: one op per 3 cycles,
// with accumulator, sticky flags and delivered-result counter.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic [N-1:0]      in_a,
  input  logic [N-1:0]      in_b,
  input  logic              in_use_acc,
  output logic [N-1:0]      alu_op1,
  output logic [N-1:0]      alu_op2,
  output logic [CMD_W-1:0]  alu_cmd,
  input  logic [N-1:0]      alu_out,
  input  logic              alu_over,
  input  logic              alu_under,
  input  logic              alu_err,
  input  logic              alu_log,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_data,
  output logic [FLAG_W-1:0] res_flags,
  output logic [N-1:0]      acc,
  output logic [FLAG_W-1:0] sticky,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  op_count
);

  state_e              state_q, state_d;
  logic [N-1:0]        op1_q, op1_d;
  logic [N-1:0]        op2_q, op2_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [N-1:0]        data_q, data_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [N-1:0]        acc_q, acc_d;
  logic [FLAG_W-1:0]   sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [N-1:0]        m_data;
  logic [FLAG_W-1:0]   m_flags;
  logic                m_acc_we;

  // err is decoded locally from the command, so the ALU's own err is ignored
  logic                unused_alu_err;
  assign unused_alu_err = alu_err;

  alu_flag_mask #(
    .N (N)
  ) u_mask (
    .cmd_i    (cmd_q),
    .out_i    (alu_out),
    .over_i   (alu_over),
    .under_i  (alu_under),
    .log_i    (alu_log),
    .data_o   (m_data),
    .flags_o  (m_flags),
    .acc_we_o (m_acc_we)
  );

  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    sticky_d = clr_sticky ? '0 : sticky_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op1_d   = in_use_acc ? acc_q : in_a;
          op2_d   = in_b;
          cmd_d   = in_cmd;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        data_d  = m_data;
        flags_d = m_flags;
        if (m_acc_we) acc_d = m_data;
        // a capture in the same cycle as a clear keeps the new flags
        sticky_d = clr_sticky ? m_flags : (sticky_q | m_flags);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_cmd   = cmd_q;
  assign res_data  = data_q;
  assign res_flags = flags_q;
  assign acc       = acc_q;
  assign sticky    = sticky_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a small behavioural ALU attached.
// Raw ALU flags deliberately leak on every command to exercise masking.
module tb_alu_sequencer;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_cmd = '0;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic             in_use_acc = 1'b0;
  logic [N-1:0]     alu_op1, alu_op2;
  logic [3:0]       alu_cmd;
  logic [N-1:0]     alu_out;
  logic             alu_over, alu_under, alu_err, alu_log;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [N-1:0]     res_data;
  logic [3:0]       res_flags;
  logic [N-1:0]     acc;
  logic [3:0]       sticky;
  logic             clr_sticky = 1'b0;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_a(in_a), .in_b(in_b),
    .in_use_acc(in_use_acc),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd),
    .alu_out(alu_out), .alu_over(alu_over),
    .alu_under(alu_under), .alu_err(alu_err),
    .alu_log(alu_log),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .acc(acc), .sticky(sticky),
    .clr_sticky(clr_sticky), .op_count(op_count)
  );

  logic [N:0] sum;
  always_comb begin
    sum       = {1'b0, alu_op1} + {1'b0, alu_op2};
    alu_out   = sum[N-1:0];
    alu_over  = sum[N];
    alu_under = alu_op1 < alu_op2;
    alu_log   = alu_op1 == alu_op2;
    alu_err   = 1'b0;
    case (alu_cmd)
      4'd0, 4'd4: ;
      4'd1: alu_out = alu_op1 - alu_op2;
      4'd2, 4'd3: alu_out = alu_op1 << alu_op2[2:0];
      4'd5: alu_log = alu_op1 > alu_op2;
      4'd6: alu_log = alu_op1 < alu_op2;
      default: begin
        alu_out = alu_op1 ^ alu_op2;
        alu_err = 1'b1;
      end
    endcase
  end

  typedef struct {
    logic [N-1:0] d;
    logic [3:0]   f;
    logic [N-1:0] a;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected result: data %0h flags %b",
                 res_data, res_flags);
      end else begin
        if (!seen) begin
          chk("latency", cyc, sb[0].cyc);
          chk("acc", {24'd0, acc}, {24'd0, sb[0].a});
          seen = 1'b1;
        end
        if (res_ready) begin
          e = sb.pop_front();
          chk("res_data", {24'd0, res_data}, {24'd0, e.d});
          chk("res_flags", {28'd0, res_flags}, {28'd0, e.f});
          seen = 1'b0;
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge when wait_done is set
  task automatic issue(input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ua,
                       input logic [7:0] ed, input logic [3:0] ef,
                       input logic [7:0] ea, input bit clr_cap,
                       input bit wait_done);
    int   n;
    exp_t t;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready timeout: got 0 expected 1");
      return;
    end
    t.d = ed; t.f = ef; t.a = ea; t.cyc = cyc + 2;
    sb.push_back(t);
    in_cmd = c; in_a = a; in_b = b; in_use_acc = ua;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (clr_cap) begin
      @(negedge clk);
      clr_sticky = 1'b1;
      @(posedge clk);
      #1 clr_sticky = 1'b0;
    end
    if (wait_done) begin
      n = 0;
      while (sb.size() != 0 && n < 40) begin
        @(posedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result timeout: got pending expected none");
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst acc", {24'd0, acc}, 32'd0);
    chk("rst sticky", {28'd0, sticky}, 32'd0);
    chk("rst op_count", {16'd0, op_count}, 32'd0);
    chk("rst alu_op1", {24'd0, alu_op1}, 32'd0);
    chk("rst alu_cmd", {28'd0, alu_cmd}, 32'd0);
    chk("rst res_data", {24'd0, res_data}, 32'd0);

    issue(4'd0, 8'h0F, 8'h0F, 1'b0, 8'h1E, 4'b0000, 8'h1E, 0, 1);
    issue(4'd0, 8'hFF, 8'hFF, 1'b0, 8'hFE, 4'b0001, 8'hFE, 0, 1);
    chk("sticky over", {28'd0, sticky}, 32'b0001);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky clr", {28'd0, sticky}, 32'b0000);

    issue(4'd0, 8'h0F, 8'h0F, 1'b0, 8'h1E, 4'b0000, 8'h1E, 0, 1);
    issue(4'd4, 8'h0F, 8'h0F, 1'b0, 8'h00, 4'b0100, 8'h1E, 0, 1);
    issue(4'd1, 8'h77, 8'h1E, 1'b1, 8'h00, 4'b0000, 8'h00, 0, 1);
    issue(4'd2, 8'h03, 8'h02, 1'b0, 8'h0C, 4'b0000, 8'h0C, 0, 1);
    issue(4'd7, 8'h0F, 8'h02, 1'b0, 8'h00, 4'b1000, 8'h0C, 0, 1);
    chk("sticky err", {28'd0, sticky}, 32'b1100);
    issue(4'd1, 8'h01, 8'h02, 1'b0, 8'hFF, 4'b0010, 8'hFF, 1, 1);
    chk("sticky set wins", {28'd0, sticky}, 32'b0010);
    issue(4'd5, 8'h05, 8'h03, 1'b0, 8'h00, 4'b0100, 8'hFF, 0, 1);
    issue(4'd6, 8'h05, 8'h03, 1'b0, 8'h00, 4'b0000, 8'hFF, 0, 1);
    issue(4'd0, 8'h55, 8'h01, 1'b1, 8'h00, 4'b0001, 8'h00, 0, 1);
    chk("sticky accum", {28'd0, sticky}, 32'b0111);
    chk("op_count 11", {16'd0, op_count}, 32'd11);

    res_ready = 1'b0;
    issue(4'd0, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000, 8'h30, 0, 0);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("stall data", {24'd0, res_data}, 32'h30);
      chk("stall flags", {28'd0, res_flags}, 32'd0);
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall op_count", {16'd0, op_count}, 32'd11);
      in_cmd = 4'd0; in_a = 8'h01; in_b = 8'h01;
      in_use_acc = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release op_count", {16'd0, op_count}, 32'd12);
    chk("release in_ready", {31'd0, in_ready}, 32'd1);

    in_cmd = 4'd0; in_a = 8'h01; in_b = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst acc", {24'd0, acc}, 32'd0);
    chk("midrst sticky", {28'd0, sticky}, 32'd0);
    chk("midrst op_count", {16'd0, op_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("midrst res_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
    end

    issue(4'd0, 8'h01, 8'h02, 1'b0, 8'h03, 4'b0000, 8'h03, 0, 1);
    chk("final op_count", {16'd0, op_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
